// File: rtl/traffic_phase_sequencer.sv
//----------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Actuated signal-phase sequencer for an intersection with N_APP approaches.
// Vehicle detector levels and the pedestrian button are latched into
// request flags. The controller cycles GREEN -> YELLOW -> ALLRED -> next
// GREEN, or into an optional pedestrian WALK phase. Green time is
// stretched between GREEN_MIN and GREEN_MAX while there is competing demand.
// With no competing demand, the current green rests indefinitely.
//
// Optional feature macro: TPS_PED_WALK_EN
//   defined   : WALK phase, pedestrian latch and walk-served flag exist;
//               ped_req adds to competing demand.
//   undefined : ped_req is ignored, walk is tied low, and state 3 is never
//               entered.
//
// Ports
//   clk      in  1                 rising-edge clock
//   rst_n    in  1                 asynchronous active-low reset
//   tick     in  1                 timing strobe (one clk wide)
//   veh_req  in  N_APP             vehicle detector levels
//   ped_req  in  1                 pedestrian button level
//   lamp_r   out N_APP             red lamp drive, bit i = approach i
//   lamp_y   out N_APP             yellow lamp drive
//   lamp_g   out N_APP             green lamp drive
//   walk     out 1                 pedestrian walk lamp
//   state    out 2                 GREEN=0, YELLOW=1, ALLRED=2, WALK=3
//   cur      out $clog2(N_APP)     current or most recent green approach
//----------------------------------------------------------------------------
module traffic_phase_sequencer #(
    parameter int N_APP     = 2,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [N_APP-1:0]           veh_req,
    input  logic                       ped_req,
    output logic [N_APP-1:0]           lamp_r,
    output logic [N_APP-1:0]           lamp_y,
    output logic [N_APP-1:0]           lamp_g,
    output logic                       walk,
    output logic [1:0]                 state,
    output logic [$clog2(N_APP)-1:0]   cur
);

    localparam int IDX_W = $clog2(N_APP);

    // A phase of length T exits on the tick that finds the timer at T-1.
    localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_WALK   = 2'd3
    } phase_e;

    phase_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [N_APP-1:0]   vehLatch_q, vehLatch_d;
    logic [N_APP-1:0]   lampR_q, lampR_d;
    logic [N_APP-1:0]   lampY_q, lampY_d;
    logic [N_APP-1:0]   lampG_q, lampG_d;

    logic [IDX_W-1:0]   nextApp;
    logic [N_APP-1:0]   curHot;
    logic [N_APP-1:0]   nextHot;
    logic [N_APP-1:0]   curNextHot;
    logic               otherReq;
    logic               pedPending;
    logic               walkWanted;
    logic               pending;
    logic               enterGreen;
    logic               enterWalk;
    logic               greenExit;

    function automatic logic [N_APP-1:0] oneHot(input logic [IDX_W-1:0] idx);
        logic [N_APP-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    assign curHot     = oneHot(cur_q);
    assign nextHot    = oneHot(nextApp);
    assign curNextHot = oneHot(cur_d);

    // Demand from any approach other than the one holding green. The
    // current approach's own latch is ignored here because it is served by
    // the green it already has.
    assign otherReq = |(vehLatch_q & ~curHot);
    assign pending  = otherReq | pedPending;

    // Round-robin choice of the next green: scan from cur+1 upward with
    // wrap-around, ending on cur itself, so with no latched request the
    // same approach gets green again.
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        nextApp = cur_q;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_APP; k++) begin
            cand = IDX_W'((int'(cur_q) + k) % N_APP);
            if (!found && vehLatch_q[cand]) begin
                nextApp = cand;
                found   = 1'b1;
            end
        end
    end

    // Green ends either at max-out under competing demand, or early
    // (gap-out) once the minimum has run and the current approach's
    // detector has gone quiet.
    assign greenExit = pending &&
                       ((timer_q >= GMAX_LAST) ||
                        ((timer_q >= GMIN_LAST) && !veh_req[cur_q]));

    // Phase sequencing. Every transition is gated by tick, so a low tick
    // freezes the phase while request latching continues.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        enterGreen = 1'b0;
        enterWalk  = 1'b0;
        case (state_q)
            ST_GREEN: begin
                if (tick && greenExit) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (tick && (timer_q == YELLOW_LAST)) begin
                    state_d = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (tick && (timer_q == ALLRED_LAST)) begin
                    if (walkWanted) begin
                        state_d   = ST_WALK;
                        enterWalk = 1'b1;
                    end else begin
                        state_d    = ST_GREEN;
                        cur_d      = nextApp;
                        enterGreen = 1'b1;
                    end
                end
            end
            ST_WALK: begin
                if (tick && (timer_q == WALK_LAST)) begin
                    state_d = ST_ALLRED;
                end
            end
        endcase
    end

    // Phase timer: restarts on every phase change, otherwise counts ticks
    // and sticks at all-ones so a resting green cannot wrap around.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Vehicle request latches. The approach holding green does not latch
    // its own detector. Entering green on an approach clears its latch,
    // and that clear beats a simultaneous set.
    always_comb begin
        logic [N_APP-1:0] setMask;
        logic [N_APP-1:0] clrMask;
        setMask    = veh_req & ~((state_q == ST_GREEN) ? curHot : '0);
        clrMask    = enterGreen ? nextHot : '0;
        vehLatch_d = (vehLatch_q | setMask) & ~clrMask;
    end

    // Lamps are decoded from the next state so that they change on the
    // same edge as the phase itself. Any approach that is neither green
    // nor yellow shows red, which also covers ALLRED and WALK.
    always_comb begin
        lampG_d = '0;
        lampY_d = '0;
        if (state_d == ST_GREEN) begin
            lampG_d = curNextHot;
        end else if (state_d == ST_YELLOW) begin
            lampY_d = curNextHot;
        end
        lampR_d = ~(lampG_d | lampY_d);
    end

    // Core state register. Reset lands in ALLRED with every approach red,
    // abandoning whatever phase was in progress and any latched demand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ALLRED;
            timer_q    <= '0;
            cur_q      <= '0;
            vehLatch_q <= '0;
            lampR_q    <= '1;
            lampY_q    <= '0;
            lampG_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cur_q      <= cur_d;
            vehLatch_q <= vehLatch_d;
            lampR_q    <= lampR_d;
            lampY_q    <= lampY_d;
            lampG_q    <= lampG_d;
        end
    end

`ifdef TPS_PED_WALK_EN
    logic pedLatch_q, pedLatch_d;
    logic walkServed_q, walkServed_d;
    logic walk_q, walk_d;

    // The served flag blocks a second walk in a row: after WALK the
    // controller must pass through a green before walking again.
    assign walkWanted = pedLatch_q & ~walkServed_q;
    assign pedPending = pedLatch_q;

    // Pedestrian latch and served flag. Entering WALK clears the latch
    // (clear beats a same-edge press) and marks the walk served; entering
    // any green re-arms it.
    always_comb begin
        pedLatch_d   = (pedLatch_q | ped_req) & ~enterWalk;
        walkServed_d = walkServed_q;
        if (enterWalk) begin
            walkServed_d = 1'b1;
        end else if (enterGreen) begin
            walkServed_d = 1'b0;
        end
        walk_d = (state_d == ST_WALK);
    end

    // Pedestrian register bank, reset alongside the core state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pedLatch_q   <= 1'b0;
            walkServed_q <= 1'b0;
            walk_q       <= 1'b0;
        end else begin
            pedLatch_q   <= pedLatch_d;
            walkServed_q <= walkServed_d;
            walk_q       <= walk_d;
        end
    end

    assign walk = walk_q;
`else
    logic unused_noPed;

    // Without the walk feature the button has no effect and WALK is never
    // requested from ALLRED.
    assign walkWanted   = 1'b0;
    assign pedPending   = 1'b0;
    assign walk         = 1'b0;
    assign unused_noPed = ped_req ^ enterWalk;
`endif

    assign lamp_r = lampR_q;
    assign lamp_y = lampY_q;
    assign lamp_g = lampG_q;
    assign state  = state_q;
    assign cur    = cur_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
//----------------------------------------------------------------------------
// tb_traffic_phase_sequencer
//
// Self-checking bench for traffic_phase_sequencer with N_APP=2, GREEN_MIN=3,
// GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1, WALK_T=3 and tick normally high.
// Directed scenarios compare against hand-derived phase sequences; a random
// run compares every clk against a phase-level reference model that tracks
// remaining ticks per phase rather than a timer.
//----------------------------------------------------------------------------
module tb_traffic_phase_sequencer;

    localparam int N_APP     = 2;
    localparam int GREEN_MIN = 3;
    localparam int GREEN_MAX = 6;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 3;
    localparam int CNT_W     = 8;
    localparam int IDX_W     = $clog2(N_APP);

`ifdef TPS_PED_WALK_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               tick;
    logic [N_APP-1:0]   veh_req;
    logic               ped_req;
    logic [N_APP-1:0]   lamp_r;
    logic [N_APP-1:0]   lamp_y;
    logic [N_APP-1:0]   lamp_g;
    logic               walk;
    logic [1:0]         state;
    logic [IDX_W-1:0]   cur;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: phase (0 G, 1 Y, 2 R, 3 W), green ticks elapsed,
    // ticks left in a fixed-length phase, and the demand sets.
    int               mPhase;
    int               mCur;
    int               mGreenTicks;
    int               mLeft;
    bit               mReq [N_APP];
    bit               mPed;
    bit               mServed;

    traffic_phase_sequencer #(
        .N_APP     (N_APP),
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .WALK_T    (WALK_T),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .veh_req (veh_req),
        .ped_req (ped_req),
        .lamp_r  (lamp_r),
        .lamp_y  (lamp_y),
        .lamp_g  (lamp_g),
        .walk    (walk),
        .state   (state),
        .cur     (cur)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the run stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog elapsed=%0t limit=2000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mPhase      = 2;
        mCur        = 0;
        mGreenTicks = 0;
        mLeft       = ALLRED_T;
        for (int i = 0; i < N_APP; i++) mReq[i] = 1'b0;
        mPed        = 1'b0;
        mServed     = 1'b0;
    endtask

    task automatic modelStep(input bit t, input logic [N_APP-1:0] v, input bit p);
        bit pend;
        bit toGreen;
        bit toWalk;
        int nPhase;
        int nCur;
        pend = PED_EN && mPed;
        for (int j = 0; j < N_APP; j++) if (j != mCur && mReq[j]) pend = 1'b1;
        nPhase  = mPhase;
        nCur    = mCur;
        toGreen = 1'b0;
        toWalk  = 1'b0;
        if (t) begin
            case (mPhase)
                0: begin
                    mGreenTicks++;
                    if (pend && (mGreenTicks >= GREEN_MAX ||
                                 (mGreenTicks >= GREEN_MIN && !v[mCur]))) begin
                        nPhase = 1;
                        mLeft  = YELLOW_T;
                    end
                end
                1: begin
                    mLeft--;
                    if (mLeft == 0) begin nPhase = 2; mLeft = ALLRED_T; end
                end
                2: begin
                    mLeft--;
                    if (mLeft == 0) begin
                        if (PED_EN && mPed && !mServed) begin
                            nPhase = 3;
                            mLeft  = WALK_T;
                            toWalk = 1'b1;
                        end else begin
                            for (int k = N_APP; k >= 1; k--)
                                if (mReq[(mCur + k) % N_APP]) nCur = (mCur + k) % N_APP;
                            nPhase      = 0;
                            mGreenTicks = 0;
                            toGreen     = 1'b1;
                        end
                    end
                end
                default: begin
                    mLeft--;
                    if (mLeft == 0) begin nPhase = 2; mLeft = ALLRED_T; end
                end
            endcase
        end
        for (int i = 0; i < N_APP; i++)
            if (v[i] && !(mPhase == 0 && i == mCur)) mReq[i] = 1'b1;
        if (PED_EN && p) mPed = 1'b1;
        if (toGreen) begin mReq[nCur] = 1'b0; mServed = 1'b0; end
        if (toWalk)  begin mPed = 1'b0; mServed = 1'b1; end
        mPhase = nPhase;
        mCur   = nCur;
    endtask

    // Drive one clk of inputs, let the DUT take the edge, advance the model,
    // and return 1 unit after the edge so outputs can be sampled.
    task automatic applyStimulus(input bit t, input logic [N_APP-1:0] v, input bit p);
        tick    = t;
        veh_req = v;
        ped_req = p;
        @(posedge clk);
        modelStep(t, v, p);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        tick    = 1'b1;
        veh_req = '0;
        ped_req = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    // Expected {r,y,g} for a phase letter G/Y/R/W with green approach c.
    function automatic logic [3*N_APP-1:0] lampsFor(input byte ph, input int c);
        logic [N_APP-1:0] h, g, y;
        h    = '0;
        h[c] = 1'b1;
        g    = (ph == "G") ? h : '0;
        y    = (ph == "Y") ? h : '0;
        return {~(g | y), y, g};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        tick    = 1'b1;
        veh_req = '0;
        ped_req = 1'b0;
        modelReset();
        #1;
        checkCount++;
        if ({lamp_r, lamp_y, lamp_g, walk} !== {2'b11, 2'b00, 2'b00, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL reset_lamps got r/y/g/w=%b/%b/%b/%b want 11/00/00/0",
                     lamp_r, lamp_y, lamp_g, walk);
        end
        checkCount++;
        if ({state, cur} !== {2'd2, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL reset_state got state=%0d cur=%0d want state=2 cur=0", state, cur);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkCount++;
        if ({lamp_g, lamp_r, state} !== {2'b01, 2'b10, 2'd0}) begin
            failCount++;
            $display("[TB] FAIL first_green got g=%b r=%b state=%0d want g=01 r=10 state=0",
                     lamp_g, lamp_r, state);
        end
        for (int k = 0; k < 50; k++) begin
            applyStimulus(1'b1, 2'b00, 1'b0);
            checkCount++;
            if ({lamp_r, lamp_y, lamp_g, walk} !== {2'b10, 2'b00, 2'b01, 1'b0}) begin
                failCount++;
                $display("[TB] FAIL idle_rest clk=%0d got r/y/g/w=%b/%b/%b/%b want 10/00/01/0",
                         k, lamp_r, lamp_y, lamp_g, walk);
            end
        end
    endtask

    task automatic test_gap_out();
        string seq;
        int    c;
        seq = "GGGYYRG";
        doReset();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, (k == 1) ? 2'b10 : 2'b00, 1'b0);
            c = (k == 6) ? 1 : 0;
            checkCount++;
            if ({lamp_r, lamp_y, lamp_g} !== lampsFor(seq[k], c) || cur !== IDX_W'(c)) begin
                failCount++;
                $display("[TB] FAIL gap_out step=%0d got r/y/g=%b/%b/%b cur=%0d want ryg=%b cur=%0d",
                         k, lamp_r, lamp_y, lamp_g, cur, lampsFor(seq[k], c), c);
            end
        end
    endtask

    task automatic test_max_out();
        string seq;
        seq = "GGGGGGYYR";
        doReset();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, (k == 1) ? 2'b11 : 2'b01, 1'b0);
            checkCount++;
            if ({lamp_r, lamp_y, lamp_g} !== lampsFor(seq[k], 0) || cur !== '0) begin
                failCount++;
                $display("[TB] FAIL max_out step=%0d got r/y/g=%b/%b/%b cur=%0d want ryg=%b cur=0",
                         k, lamp_r, lamp_y, lamp_g, cur, lampsFor(seq[k], 0));
            end
        end
    endtask

`ifdef TPS_PED_WALK_EN
    task automatic test_ped_walk();
        string seq;
        byte   ph;
        seq = "GGGYYRWWWRG";
        doReset();
        for (int k = 0; k < 31; k++) begin
            applyStimulus(1'b1, 2'b00, k == 1);
            ph = (k < 11) ? seq[k] : "G";
            checkCount++;
            if ({lamp_r, lamp_y, lamp_g} !== lampsFor(ph, 0) || walk !== (ph == "W")) begin
                failCount++;
                $display("[TB] FAIL ped_walk step=%0d got r/y/g=%b/%b/%b walk=%b want ryg=%b walk=%b",
                         k, lamp_r, lamp_y, lamp_g, walk, lampsFor(ph, 0), ph == "W");
            end
        end
    endtask
`else
    task automatic test_ped_ignored();
        doReset();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 2'b00, (k == 1) || (k == 5));
            checkCount++;
            if ({lamp_r, lamp_y, lamp_g, walk} !== {2'b10, 2'b00, 2'b01, 1'b0}) begin
                failCount++;
                $display("[TB] FAIL ped_ignored step=%0d got r/y/g/w=%b/%b/%b/%b want 10/00/01/0",
                         k, lamp_r, lamp_y, lamp_g, walk);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_yellow();
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, (k == 1) ? 2'b10 : 2'b00, 1'b0);
        checkCount++;
        if (lamp_y !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL pre_reset_yellow got y=%b want 01", lamp_y);
        end
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkCount++;
        if ({lamp_r, lamp_y, lamp_g, state} !== {2'b11, 2'b00, 2'b00, 2'd2}) begin
            failCount++;
            $display("[TB] FAIL async_reset got r/y/g=%b/%b/%b state=%0d want 11/00/00 state=2",
                     lamp_r, lamp_y, lamp_g, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 2'b00, 1'b0);
            checkCount++;
            if ({lamp_g, lamp_r} !== {2'b01, 2'b10} || cur !== '0) begin
                failCount++;
                $display("[TB] FAIL reset_drops_req step=%0d got g=%b r=%b cur=%0d want g=01 r=10 cur=0",
                         k, lamp_g, lamp_r, cur);
            end
        end
    endtask

    task automatic test_tick_freeze();
        byte ph;
        doReset();
        applyStimulus(1'b1, 2'b00, 1'b0);
        for (int k = 1; k < 14; k++) begin
            applyStimulus(k >= 11, (k == 1) ? 2'b10 : 2'b00, 1'b0);
            ph = (k == 13) ? "Y" : "G";
            checkCount++;
            if ({lamp_r, lamp_y, lamp_g} !== lampsFor(ph, 0)) begin
                failCount++;
                $display("[TB] FAIL tick_freeze step=%0d got r/y/g=%b/%b/%b want ryg=%b",
                         k, lamp_r, lamp_y, lamp_g, lampsFor(ph, 0));
            end
        end
    endtask

    task automatic test_random_model();
        logic [N_APP-1:0] hold;
        logic [N_APP-1:0] h, eg, ey;
        bit               t, p;
        doReset();
        hold = '0;
        for (int s = 0; s < 1500; s++) begin
            if (s == 750) doReset();
            for (int i = 0; i < N_APP; i++)
                if ($urandom_range(0, 7) == 0) hold[i] = ~hold[i];
            t = ($urandom_range(0, 9) != 0);
            p = ($urandom_range(0, 30) == 0);
            applyStimulus(t, hold, p);
            h        = '0;
            h[mCur]  = 1'b1;
            eg       = (mPhase == 0) ? h : '0;
            ey       = (mPhase == 1) ? h : '0;
            checkCount++;
            if ({lamp_r, lamp_y, lamp_g, walk, state, cur} !==
                {~(eg | ey), ey, eg, mPhase == 3, 2'(mPhase), IDX_W'(mCur)}) begin
                failCount++;
                $display("[TB] FAIL random_model step=%0d got r/y/g/w=%b/%b/%b/%b st=%0d cur=%0d want %b/%b/%b/%b st=%0d cur=%0d",
                         s, lamp_r, lamp_y, lamp_g, walk, state, cur,
                         ~(eg | ey), ey, eg, mPhase == 3, mPhase, mCur);
            end
            checkCount++;
            if (((lamp_r ^ lamp_y ^ lamp_g) & ~(lamp_r & lamp_y) & ~(lamp_r & lamp_g) &
                 ~(lamp_y & lamp_g)) !== '1) begin
                failCount++;
                $display("[TB] FAIL one_lamp step=%0d got r/y/g=%b/%b/%b want exactly one per approach",
                         s, lamp_r, lamp_y, lamp_g);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        tick    = 1'b0;
        veh_req = '0;
        ped_req = 1'b0;
        modelReset();
        test_reset();
        test_gap_out();
        test_max_out();
`ifdef TPS_PED_WALK_EN
        test_ped_walk();
`else
        test_ped_ignored();
`endif
        test_reset_mid_yellow();
        test_tick_freeze();
        test_random_model();
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Parametrised, actuated signal-phase sequencer for an intersection with `N_APP` approaches and an optional pedestrian walk phase. It generates registered red/yellow/green lamp drives per approach and a walk lamp, driven by latched vehicle and pedestrian requests. Green time is stretched between minimum and maximum bounds. It supersedes the fixed one-hot light decoder and sits between the detector/button front end and the lamp output drivers.

## Interface
- `N_APP`, 2: number of approaches, ≥2.
- `GREEN_MIN`, 8: minimum green, in ticks, ≥1.
- `GREEN_MAX`, 32: maximum green under competing demand, in ticks, ≥`GREEN_MIN`.
- `YELLOW_T`, 4: yellow duration, in ticks, ≥1.
- `ALLRED_T`, 2: all-red clearance, in ticks, ≥1.
- `WALK_T`, 6: walk duration, in ticks, ≥1.
- `CNT_W`, 8: timer width. All durations must be ≤ 2^`CNT_W`−1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: timing strobe, one clk wide. Tied high means 1 tick = 1 clk.
- `veh_req` in `N_APP`: vehicle detector levels, sampled every clk.
- `ped_req` in 1: pedestrian button level, sampled every clk.
- `lamp_r`, `lamp_y`, `lamp_g` out `N_APP` each: lamp drives, bit i = approach i.
- `walk` out 1: pedestrian walk lamp.
- `state` out 2: GREEN=0, YELLOW=1, ALLRED=2, WALK=3.
- `cur` out `$clog2(N_APP)`: index of the current or last green approach.

## Operation
- Reset values: `state`=ALLRED, timer=0, `cur`=0, all request latches=0, `lamp_r`=all ones, `lamp_y`=0, `lamp_g`=0, `walk`=0.
- Request latches:
  - `req_q[i]` is set when `veh_req[i]`=1, except for i=`cur` while in GREEN.
  - `req_q[i]` is cleared on entry to GREEN(i).
  - `ped_q` is set by `ped_req` and cleared on entry to WALK.
  - When a set and a clear land on the same edge, the clear wins.
- `pending` = (any `req_q[j]`, j≠`cur`) OR `ped_q`.
- Timer:
  - Cleared on every state entry.
  - Increments on `tick`.
  - Saturates at 2^`CNT_W`−1.
  - A state of duration T exits on the tick where timer==T−1, so it lasts exactly T ticks.
- GREEN(`cur`) exits to YELLOW on a tick where either:
  - timer ≥ `GREEN_MAX`−1 and `pending`, or
  - timer ≥ `GREEN_MIN`−1 and `pending` and `veh_req[cur]`=0 (gap-out).
  - With no `pending`, GREEN rests indefinitely.
- YELLOW lasts `YELLOW_T` ticks, then goes to ALLRED.
- ALLRED lasts `ALLRED_T` ticks, then:
  - If `ped_q` is set and the walk phase has not just been served, go to WALK.
  - Otherwise go to GREEN(next).
  - next = the first j with `req_q[j]`, searching round-robin from `cur`+1 modulo `N_APP`. If none, next = `cur`.
- WALK lasts `WALK_T` ticks, then goes to ALLRED. A served flag prevents re-entering WALK until a GREEN has been entered.
- Lamp decode, registered from the next state:
  - GREEN: `lamp_g` = onehot(`cur`).
  - YELLOW: `lamp_y` = onehot(`cur`).
  - All other approaches show red.
  - `walk`=1 only in WALK.
  - Exactly one of r/y/g is high per approach at all times.

## Timing
- All outputs are registered.
- A transition takes effect on the clk edge that samples the qualifying `tick`. Outputs change at that edge (latency 0 clk after the tick edge).
- A request asserted on clk edge n is visible to `pending` at edge n+1.
- `tick`=0 freezes all timers and states. Requests still latch.
- `rst_n` low at any point: outputs take reset values immediately (asynchronously), and an in-progress yellow or walk is abandoned. After release, the first `tick` counts as ALLRED tick 0.

## Configuration
- `TPS_PED_WALK_EN` defined: WALK state, `ped_q`, and the served flag are present. `ped_req` contributes to `pending`.
- Undefined: `ped_req` is ignored, `walk` is tied 0, and state 3 is unreachable. ALLRED always goes to GREEN(next).

## Test plan
All scenarios use `tick`=1, `N_APP`=2, `GREEN_MIN`=3, `GREEN_MAX`=6, `YELLOW_T`=2, `ALLRED_T`=1, `WALK_T`=3.

- Reset then idle, no requests:
  - During reset: `lamp_r`=2'b11.
  - After 1 clk: `lamp_g`=2'b01, `lamp_r`=2'b10.
  - Stays there for 50 clk.
- One-clk `veh_req[1]` pulse at green clk 0, `veh_req[0]`=0 (gap-out):
  - Green 3 clk, `lamp_y`=2'b01 for 2 clk, all red 1 clk, then `lamp_g`=2'b10 and `cur`=1.
- `veh_req[0]` held 1, `veh_req[1]` pulsed:
  - Green on approach 0 lasts 6 clk (max-out), then yellow 2 clk.
- Macro defined, `ped_req` pulse during green 0, no vehicle requests:
  - Green 3, yellow 2, all-red 1.
  - Then `walk`=1 with `lamp_r`=2'b11 for 3 clk.
  - Then all-red 1, then `lamp_g`=2'b01.
  - `walk` never re-asserts.
- `rst_n` driven low in the middle of yellow:
  - Same clk: `lamp_r`=2'b11, `lamp_y`=0, `state`=2.
  - Pending requests are lost.
- `tick` held 0 for 10 clk during green:
  - Lamps are unchanged.
  - The green duration in ticks still equals 3 once `tick` resumes.
